// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
// Holds the default operand width and the FSM state encoding.
package div_pkg;

    localparam int unsigned DIV_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage : div_pkg

// File: rtl/div8_seq_if.sv
// Request/result bundle for div8_seq.
//   master: drives start, dividend_in, divisor_in; observes results.
//   slave : the divider; drives busy, done, quotient_out, remainder_out,
//           div_zero, ovf.
interface div8_seq_if
    import div_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_DATA_W
);

    logic              start;
    logic [DATA_W-1:0] dividend_in;
    logic [DATA_W-1:0] divisor_in;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] quotient_out;
    logic [DATA_W-1:0] remainder_out;
    logic              div_zero;
    logic              ovf;

    modport master (
        output start, dividend_in, divisor_in,
        input  busy, done, quotient_out, remainder_out, div_zero, ovf
    );

    modport slave (
        input  start, dividend_in, divisor_in,
        output busy, done, quotient_out, remainder_out, div_zero, ovf
    );

endinterface : div8_seq_if

// File: rtl/div_step.sv
// One restoring shift/subtract iteration on unsigned magnitudes (no state).
//   rem_i  : partial remainder, always < dvsr_i on entry (or dvsr_i == 0)
//   quo_i  : dividend/quotient shift register; MSB feeds the remainder
//   dvsr_i : divisor magnitude
//   rem_o  : next partial remainder
//   quo_o  : next shift register, new quotient bit shifted in at LSB
module div_step
    import div_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] dvsr_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    // One extra bit: the shifted remainder can reach 2*dvsr-1.
    logic [DATA_W:0] rem_sh;
    logic [DATA_W:0] dvsr_ext;
    logic            fits;

    always_comb begin
        rem_sh   = {rem_i, quo_i[DATA_W-1]};
        dvsr_ext = {1'b0, dvsr_i};
        fits     = (rem_sh >= dvsr_ext);
        // When the subtraction fits, the difference is < dvsr and fits DATA_W.
        rem_o    = fits ? DATA_W'(rem_sh - dvsr_ext) : rem_sh[DATA_W-1:0];
        quo_o    = {quo_i[DATA_W-2:0], fits};
    end

endmodule : div_step

// File: rtl/div8_seq.sv
// Sequential signed divider: DATA_W restoring iterations, fixed latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start  : request, sampled only when idle
//   bus.dividend_in / divisor_in : signed operands, captured with start
//   bus.busy   : operation in progress
//   bus.done   : one-cycle pulse, DATA_W+1 cycles after the start edge
//   bus.quotient_out / remainder_out : signed results, held until next done
//   bus.div_zero / ovf : divide-by-zero and most-negative/-1 flags
module div8_seq
    import div_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_DATA_W
) (
    input  logic       clk,
    input  logic       rst_n,
    div8_seq_if.slave  bus
);

    localparam int unsigned           CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0]     MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

    div_state_e        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [DATA_W-1:0] rem_q,      rem_d;
    logic [DATA_W-1:0] quo_q,      quo_d;
    logic [DATA_W-1:0] dvsr_q,     dvsr_d;
    logic [DATA_W-1:0] dividend_q, dividend_d;
    logic              sign_a_q,   sign_a_d;
    logic              sign_b_q,   sign_b_d;
    logic              dz_pend_q,  dz_pend_d;
    logic              ovf_pend_q, ovf_pend_d;

    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic [DATA_W-1:0] quot_out_q, quot_out_d;
    logic [DATA_W-1:0] rem_out_q,  rem_out_d;
    logic              div_zero_q, div_zero_d;
    logic              ovf_q,      ovf_d;

    logic [DATA_W-1:0] step_rem;
    logic [DATA_W-1:0] step_quo;
    logic [DATA_W-1:0] dvd_mag;
    logic [DATA_W-1:0] dvs_mag;

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    // Operand magnitudes; the most-negative value maps to 2^(DATA_W-1) unsigned.
    always_comb begin
        dvd_mag = bus.dividend_in[DATA_W-1] ? DATA_W'(-bus.dividend_in) : bus.dividend_in;
        dvs_mag = bus.divisor_in[DATA_W-1]  ? DATA_W'(-bus.divisor_in)  : bus.divisor_in;
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        dividend_d = dividend_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        dz_pend_d  = dz_pend_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_CALC;
                    cnt_d      = '0;
                    rem_d      = '0;
                    quo_d      = dvd_mag;
                    dvsr_d     = dvs_mag;
                    dividend_d = bus.dividend_in;
                    sign_a_d   = bus.dividend_in[DATA_W-1];
                    sign_b_d   = bus.divisor_in[DATA_W-1];
                    dz_pend_d  = (bus.divisor_in == '0);
                    ovf_pend_d = (bus.dividend_in == MOST_NEG) && (&bus.divisor_in);
                    busy_d     = 1'b1;
                end
            end

            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                div_zero_d = dz_pend_q;
                ovf_d      = ovf_pend_q;
                if (dz_pend_q) begin
                    quot_out_d = '1;
                    rem_out_d  = dividend_q;
                end else if (ovf_pend_q) begin
                    quot_out_d = MOST_NEG;
                    rem_out_d  = '0;
                end else begin
                    quot_out_d = (sign_a_q ^ sign_b_q) ? DATA_W'(-quo_q) : quo_q;
                    rem_out_d  = sign_a_q ? DATA_W'(-rem_q) : rem_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            dividend_q <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            dz_pend_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvsr_q     <= dvsr_d;
            dividend_q <= dividend_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            dz_pend_q  <= dz_pend_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.quotient_out  = quot_out_q;
    assign bus.remainder_out = rem_out_q;
    assign bus.div_zero      = div_zero_q;
    assign bus.ovf           = ovf_q;

endmodule : div8_seq

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: directed scenarios plus random operands
// checked against an integer-arithmetic reference model.
module tb_div8_seq;

    localparam int unsigned W   = 8;
    localparam int          LAT = W + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div8_seq_if #(.DATA_W(W)) bus ();

    div8_seq #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference: signed division truncating toward zero plus the two special cases.
    function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic dz, output logic ov);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (bi == 0) begin
            q  = 8'hFF;
            r  = a;
            dz = 1'b1;
        end else if (ai == -128 && bi == -1) begin
            q  = 8'h80;
            r  = 8'h00;
            ov = 1'b1;
        end else begin
            q = 8'(ai / bi);
            r = 8'(ai % bi);
        end
    endfunction

    // Issues one operation (called #1 after an edge) and waits for done.
    // lat = cycles from start edge to done (-1 on timeout); held = results
    // stayed at their previous values while busy; busy_ok = busy high after
    // the start edge and low with done.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic dz, output logic ov,
                          output int lat, output bit held, output bit busy_ok);
        logic [7:0] q0;
        logic [7:0] r0;
        q0 = bus.quotient_out;
        r0 = bus.remainder_out;
        bus.start       = 1'b1;
        bus.dividend_in = a;
        bus.divisor_in  = b;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.dividend_in = 8'($urandom);
        bus.divisor_in  = 8'($urandom);
        lat     = -1;
        held    = 1'b1;
        busy_ok = (bus.busy === 1'b1);
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = n;
                if (bus.busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (bus.quotient_out !== q0 || bus.remainder_out !== r0) held = 1'b0;
        end
        q  = bus.quotient_out;
        r  = bus.remainder_out;
        dz = bus.div_zero;
        ov = bus.ovf;
    endtask

    task automatic test_reset();
        bus.start       = 1'b0;
        bus.dividend_in = 8'h00;
        bus.divisor_in  = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.busy, bus.done, bus.quotient_out, bus.remainder_out, bus.div_zero, bus.ovf} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b q=%h r=%h dz=%b ov=%b want all 0",
                     bus.busy, bus.done, bus.quotient_out, bus.remainder_out, bus.div_zero, bus.ovf);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [7:0] q, r;
        logic dz, ov;
        int lat;
        bit held, bok;
        run_op(8'd100, 8'd7, q, r, dz, ov, lat, held, bok);
        total++;
        if (lat !== LAT) begin bad++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
        total++;
        if ({q, r, dz, ov} !== {8'd14, 8'd2, 2'b00}) begin
            bad++;
            $display("FAIL basic_100_7 got q=%0d r=%0d dz=%b ov=%b want 14 2 0 0", q, r, dz, ov);
        end
        total++;
        if (bok !== 1'b1) begin bad++; $display("FAIL basic_busy got %b want 1", bok); end
        @(posedge clk);
        #1;
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got %b want 0", bus.done); end
    endtask

    task automatic test_signs();
        logic [7:0] a_t [3];
        logic [7:0] b_t [3];
        logic [7:0] q, r, eq, er;
        logic dz, ov, edz, eov;
        int lat;
        bit held, bok;
        a_t = '{8'(-100), 8'd100, 8'(-100)};
        b_t = '{8'd7, 8'(-7), 8'(-7)};
        for (int i = 0; i < 3; i++) begin
            ref_div(a_t[i], b_t[i], eq, er, edz, eov);
            run_op(a_t[i], b_t[i], q, r, dz, ov, lat, held, bok);
            total++;
            if ({q, r, dz, ov, lat} !== {eq, er, edz, eov, LAT}) begin
                bad++;
                $display("FAIL signs_%0d got q=%0d r=%0d dz=%b ov=%b lat=%0d want %0d %0d %b %b %0d",
                         i, $signed(q), $signed(r), dz, ov, lat, $signed(eq), $signed(er), edz, eov, LAT);
            end
        end
    endtask

    task automatic test_special();
        logic [7:0] q, r;
        logic dz, ov;
        int lat;
        bit held, bok;
        run_op(8'h80, 8'hFF, q, r, dz, ov, lat, held, bok);
        total++;
        if ({q, r, dz, ov, lat} !== {8'h80, 8'h00, 1'b0, 1'b1, LAT}) begin
            bad++;
            $display("FAIL ovf_case got q=%h r=%h dz=%b ov=%b lat=%0d want 80 00 0 1 %0d", q, r, dz, ov, lat, LAT);
        end
        run_op(8'd5, 8'd0, q, r, dz, ov, lat, held, bok);
        total++;
        if ({q, r, dz, ov, lat} !== {8'hFF, 8'd5, 1'b1, 1'b0, LAT}) begin
            bad++;
            $display("FAIL div_zero_case got q=%h r=%h dz=%b ov=%b lat=%0d want ff 05 1 0 %0d", q, r, dz, ov, lat, LAT);
        end
    endtask

    task automatic test_start_ignored();
        int dones;
        int first;
        logic [7:0] q, r;
        bus.start       = 1'b1;
        bus.dividend_in = 8'd100;
        bus.divisor_in  = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0;
        first = -1;
        q = 8'h00;
        r = 8'h00;
        for (int n = 1; n <= 25; n++) begin
            if (n == 3) begin
                bus.start       = 1'b1;
                bus.dividend_in = 8'd9;
                bus.divisor_in  = 8'd3;
            end
            if (n == 4) bus.start = 1'b0;
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                dones++;
                if (first < 0) begin
                    first = n;
                    q = bus.quotient_out;
                    r = bus.remainder_out;
                end
            end
        end
        total++;
        if (dones !== 1) begin bad++; $display("FAIL ignore_start_dones got %0d want 1", dones); end
        total++;
        if ({q, r, first} !== {8'd14, 8'd2, LAT}) begin
            bad++;
            $display("FAIL ignore_start_result got q=%0d r=%0d lat=%0d want 14 2 %0d", q, r, first, LAT);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        logic [7:0] q, r;
        logic dz, ov;
        int lat;
        bit held, bok;
        bus.start       = 1'b1;
        bus.dividend_in = 8'd20;
        bus.divisor_in  = 8'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.quotient_out, bus.remainder_out, bus.div_zero, bus.ovf} !== 20'h0) begin
            bad++;
            $display("FAIL abort_outputs got busy=%b done=%b q=%h r=%h dz=%b ov=%b want all 0",
                     bus.busy, bus.done, bus.quotient_out, bus.remainder_out, bus.div_zero, bus.ovf);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL abort_no_done got %0d want 0", dones); end
        run_op(8'd50, 8'd5, q, r, dz, ov, lat, held, bok);
        total++;
        if ({q, r, dz, ov, lat} !== {8'd10, 8'd0, 2'b00, LAT}) begin
            bad++;
            $display("FAIL after_abort got q=%0d r=%0d dz=%b ov=%b lat=%0d want 10 0 0 0 %0d", q, r, dz, ov, lat, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q, r;
        logic dz, ov;
        int lat;
        bit held, bok;
        run_op(8'd127, 8'd1, q, r, dz, ov, lat, held, bok);
        total++;
        if ({q, r, lat} !== {8'd127, 8'd0, LAT}) begin
            bad++;
            $display("FAIL b2b_first got q=%0d r=%0d lat=%0d want 127 0 %0d", q, r, lat, LAT);
        end
        // Issued straight away, while done is still high.
        run_op(8'd1, 8'd127, q, r, dz, ov, lat, held, bok);
        total++;
        if ({q, r, lat} !== {8'd0, 8'd1, LAT}) begin
            bad++;
            $display("FAIL b2b_second got q=%0d r=%0d lat=%0d want 0 1 %0d", q, r, lat, LAT);
        end
        total++;
        if (held !== 1'b1) begin bad++; $display("FAIL b2b_hold got %b want 1", held); end
    endtask

    task automatic test_random();
        logic [7:0] a, b, q, r, eq, er;
        logic dz, ov, edz, eov;
        int lat;
        bit held, bok;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (i % 8 == 0) b = 8'h00;
            if (i % 8 == 1) begin a = 8'h80; b = 8'hFF; end
            if (i % 8 == 2) b = 8'hFF;
            ref_div(a, b, eq, er, edz, eov);
            run_op(a, b, q, r, dz, ov, lat, held, bok);
            total++;
            if ({q, r, dz, ov, lat, held, bok} !== {eq, er, edz, eov, LAT, 1'b1, 1'b1}) begin
                bad++;
                $display("FAIL rand_%0d a=%h b=%h got q=%h r=%h dz=%b ov=%b lat=%0d held=%b busy=%b want %h %h %b %b %0d 1 1",
                         i, a, b, q, r, dz, ov, lat, held, bok, eq, er, edz, eov, LAT);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_special();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div8_seq

// File: doc/div8_seq.md
DIV8_SEQ -- requirements
Module: div8_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width in bits.
REQ-002 SHALL have input clk, 1 bit, rising-edge clock.
REQ-003 SHALL have input rst_n, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have input start, 1 bit, request; sampled only in IDLE.
REQ-005 SHALL have input dividend_in, DATA_W bits, signed two's-complement dividend.
REQ-006 SHALL have input divisor_in, DATA_W bits, signed two's-complement divisor.
REQ-007 SHALL have output busy, 1 bit, high while a division is in progress.
REQ-008 SHALL have output done, 1 bit, single-cycle pulse when results become valid.
REQ-009 SHALL have output quotient_out, DATA_W bits, signed quotient.
REQ-010 SHALL have output remainder_out, DATA_W bits, signed remainder.
REQ-011 SHALL have output div_zero, 1 bit, flag: last divisor was zero.
REQ-012 SHALL have output ovf, 1 bit, flag: last operation was most-negative / -1.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE; the state leaves reset in IDLE.
REQ-014 SHALL in IDLE with start=1 capture both operands, absolute values and sign bits, and enter CALC at the next edge; busy=1 from that edge.
REQ-015 SHALL in CALC perform one restoring shift/subtract iteration per cycle on unsigned magnitudes for exactly DATA_W cycles, then enter DONE.
REQ-016 SHALL in DONE assert done=1 for exactly one cycle, update quotient_out/remainder_out/flags, drop busy, and return to IDLE.
REQ-017 SHALL give a fixed latency: done is high DATA_W+1 cycles after the edge that samples start.
REQ-018 SHALL truncate the quotient toward zero; remainder takes the sign of the dividend; |remainder| < |divisor|.
REQ-019 SHALL on divisor zero output quotient all-ones, remainder = dividend, div_zero=1, ovf=0, with the normal latency.
REQ-020 SHALL on dividend = -2^(DATA_W-1) and divisor = -1 output quotient = -2^(DATA_W-1) (wrapped), remainder 0, ovf=1.
REQ-021 SHALL otherwise clear div_zero and ovf when results are updated.
REQ-022 SHALL ignore start while busy; operand inputs may change freely after capture.
REQ-023 SHALL hold quotient_out, remainder_out and flags stable from done until the next DONE state.
REQ-024 SHALL accept start in IDLE on the cycle immediately after done (back-to-back operation).

Reset
REQ-025 SHALL on rst_n low, at any time including mid-CALC, abort the operation and go to IDLE; busy, done, quotient_out, remainder_out, div_zero and ovf all 0.
REQ-026 SHALL not produce a done pulse for an operation aborted by reset.

Structure
REQ-027 SHALL place the DATA_W default and the state encodings (IDLE, CALC, DONE) in shared package div_pkg.
REQ-028 SHALL factor one restoring iteration into combinational sub-module div_step (inputs: partial remainder, quotient/dividend shift register, divisor magnitude; outputs: next values).
REQ-029 SHALL keep all sequential logic in div8_seq; div_step holds no state.

Verification
REQ-030 SHALL cover: 100 / 7 -> quotient 14, remainder 2, flags 0, done exactly 9 cycles after start edge.
REQ-031 SHALL cover sign combinations: -100/7 -> -14,-2; 100/-7 -> -14,2; -100/-7 -> 14,-2.
REQ-032 SHALL cover: -128 / -1 -> quotient -128 (8'h80), remainder 0, ovf=1; then 5 / 0 -> quotient 8'hFF, remainder 5, div_zero=1, ovf=0.
REQ-033 SHALL cover: start pulsed again 3 cycles into CALC with other operands -> ignored, first result unchanged, single done.
REQ-034 SHALL cover: rst_n low at CALC cycle 4 -> all outputs 0, no done; new start 50/5 after release -> 10, 0.
REQ-035 SHALL cover: back-to-back start the cycle after done (127/1 then 1/127) -> 127,0 then 0,1.
